// File: rtl/uart_rx_ext_if.sv
// Receive-side bus from uart_rx_ext to the RX FIFO / interface logic.
// master: the receiver drives the done strobe, data word and error flags.
// slave : the consumer samples them.
interface uart_rx_ext_if #(
  parameter int D_BIT = 8
);
  logic             rx_done_tick;
  logic [D_BIT-1:0] data;
  logic             frame_err;
  logic             parity_err;

  modport master (output rx_done_tick, output data, output frame_err, output parity_err);
  modport slave  (input  rx_done_tick, input  data, input  frame_err, input  parity_err);
endinterface

// File: rtl/uart_rx_ext.sv
// Parametrised UART receiver, oversampled by an external baud tick.
// The line goes through a 2-flop synchroniser. A start bit is accepted only
// if it is still low at its midpoint. A low stop bit sets the framing-error
// flag. Every frame, including one with errors, ends in a done pulse.
// Optional parity checking is built only when the RX_PARITY_EN macro is
// defined. Without it, o_parity_err is tied to 0.
//
// state  | meaning
// IDLE   | line idle, waiting for rx_s low
// START  | timing to mid start bit, rejecting glitches
// DATA   | sampling D_BIT data bits, LSB first
// PARITY | sampling the parity bit (RX_PARITY_EN only)
// STOP   | stop period; sample stop bit, then finish the frame
module uart_rx_ext #(
  parameter int D_BIT      = 8,
  parameter int OVS        = 16,
  parameter int SB_TICK    = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_rx,
  input  logic               i_s_tick,
  uart_rx_ext_if.master      rx_if
);

  localparam int S_W = $clog2(SB_TICK);
  localparam int N_W = $clog2(D_BIT);
  localparam logic [S_W-1:0] S_HALF = S_W'(OVS/2 - 1);
  localparam logic [S_W-1:0] S_BIT  = S_W'(OVS - 1);
  localparam logic [S_W-1:0] S_STOP = S_W'(SB_TICK - 1);
  localparam logic [N_W-1:0] N_LAST = N_W'(D_BIT - 1);

`ifdef RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t           state_q, state_d;
  logic             rx_meta_q, rx_s_q;
  logic [S_W-1:0]   s_q, s_d;
  logic [N_W-1:0]   n_q, n_d;
  logic [D_BIT-1:0] b_q, b_d;
  logic             fe_q, fe_d;
  logic             done_q, done_d;
  logic [D_BIT-1:0] data_q, data_d;
  logic             frame_err_q, frame_err_d;
`ifdef RX_PARITY_EN
  logic             par_q, par_d;
  logic             pe_q, pe_d;
  logic             parity_err_q, parity_err_d;
  localparam logic  ODD = (PARITY_ODD != 0);
`endif

  // State, datapath and output registers, plus the line synchroniser.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      state_q      <= IDLE;
      s_q          <= '0;
      n_q          <= '0;
      b_q          <= '0;
      fe_q         <= 1'b0;
      done_q       <= 1'b0;
      data_q       <= '0;
      frame_err_q  <= 1'b0;
`ifdef RX_PARITY_EN
      par_q        <= 1'b0;
      pe_q         <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_meta_q    <= i_rx;
      rx_s_q       <= rx_meta_q;
      state_q      <= state_d;
      s_q          <= s_d;
      n_q          <= n_d;
      b_q          <= b_d;
      fe_q         <= fe_d;
      done_q       <= done_d;
      data_q       <= data_d;
      frame_err_q  <= frame_err_d;
`ifdef RX_PARITY_EN
      par_q        <= par_d;
      pe_q         <= pe_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // Next state, tick/bit counters, shift register and per-frame flags.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    fe_d    = fe_q;
`ifdef RX_PARITY_EN
    par_d   = par_q;
    pe_d    = pe_q;
`endif
    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (i_s_tick) begin
          if (s_q == S_HALF) begin
            s_d = '0;
            if (!rx_s_q) begin
              state_d = DATA;
              n_d     = '0;
`ifdef RX_PARITY_EN
              par_d   = 1'b0;
`endif
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      DATA: begin
        if (i_s_tick) begin
          if (s_q == S_BIT) begin
            s_d = '0;
            b_d = {rx_s_q, b_q[D_BIT-1:1]};
`ifdef RX_PARITY_EN
            par_d = par_q ^ rx_s_q;
`endif
            if (n_q == N_LAST) begin
`ifdef RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              n_d = n_q + N_W'(1);
            end
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
`ifdef RX_PARITY_EN
      PARITY: begin
        if (i_s_tick) begin
          if (s_q == S_BIT) begin
            s_d     = '0;
            pe_d    = rx_s_q ^ par_q ^ ODD;
            state_d = STOP;
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
`endif
      STOP: begin
        if (i_s_tick) begin
          // With SB_TICK == OVS the stop sample and the exit share one tick.
          if (s_q == S_BIT) fe_d = ~rx_s_q;
          if (s_q == S_STOP) begin
            s_d     = '0;
            state_d = IDLE;
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        s_d     = '0;
      end
    endcase
  end

  // Output registers: publish word and flags together with the done pulse.
  always_comb begin
    done_d      = 1'b0;
    data_d      = data_q;
    frame_err_d = frame_err_q;
`ifdef RX_PARITY_EN
    parity_err_d = parity_err_q;
`endif
    if (state_q == STOP && i_s_tick && s_q == S_STOP) begin
      done_d      = 1'b1;
      data_d      = b_q;
      frame_err_d = fe_d;
`ifdef RX_PARITY_EN
      parity_err_d = pe_q;
`endif
    end
  end

  assign rx_if.rx_done_tick = done_q;
  assign rx_if.data         = data_q;
  assign rx_if.frame_err    = frame_err_q;
`ifdef RX_PARITY_EN
  assign rx_if.parity_err   = parity_err_q;
`else
  assign rx_if.parity_err   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ext.sv
// Scoreboard bench for uart_rx_ext: two instances (8 data/1 stop and
// 7 data/2 stop). Expected frames are queued when sent and compared on each
// done pulse.
module tb_uart_rx_ext;

  localparam int OVS = 16;
`ifdef RX_PARITY_EN
  localparam int EXP_B_TICKS = 8 + 7*OVS + OVS + 32;
`else
  localparam int EXP_B_TICKS = 8 + 7*OVS + 32;
`endif

  typedef struct packed {
    logic [8:0] data;
    logic       fe;
    logic       pe;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_a = 1'b1;
  logic rx_b = 1'b1;
  logic [1:0] tick_div = 2'd0;
  logic s_tick;
  int   tick_total = 0;
  int   b_start_tick = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  uart_rx_ext_if #(.D_BIT(8)) if_a ();
  uart_rx_ext_if #(.D_BIT(7)) if_b ();

  uart_rx_ext #(.D_BIT(8), .OVS(OVS), .SB_TICK(16), .PARITY_ODD(0)) u_a (
    .i_clk(clk), .i_reset(rst), .i_rx(rx_a), .i_s_tick(s_tick), .rx_if(if_a));

  uart_rx_ext #(.D_BIT(7), .OVS(OVS), .SB_TICK(32), .PARITY_ODD(0)) u_b (
    .i_clk(clk), .i_reset(rst), .i_rx(rx_b), .i_s_tick(s_tick), .rx_if(if_b));

  always #5 clk = ~clk;

  // Tick changes on the falling edge so it is stable at every rising edge.
  always @(negedge clk) tick_div <= tick_div + 2'd1;
  assign s_tick = (tick_div == 2'd3);
  always @(posedge clk) if (s_tick) tick_total <= tick_total + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (!s_tick) @(posedge clk);
    end
    #1;
  endtask

  task automatic drive(input bit to_b, input logic v, input int n);
    if (to_b) rx_b = v;
    else      rx_a = v;
    wait_ticks(n);
  endtask

  task automatic send(input bit to_b, input logic [8:0] d, input int nb,
                      input bit par_flip, input bit stop_low, input int stop_bits);
    exp_t e;
    logic [8:0] m;
    m = d & ((9'h1 << nb) - 9'h1);
    e.data = m;
    e.fe   = stop_low;
`ifdef RX_PARITY_EN
    e.pe   = par_flip;
`else
    e.pe   = 1'b0;
`endif
    if (to_b) begin
      q_b.push_back(e);
      b_start_tick = tick_total;
    end else begin
      q_a.push_back(e);
    end
    drive(to_b, 1'b0, OVS);
    for (int i = 0; i < nb; i++) drive(to_b, m[i], OVS);
`ifdef RX_PARITY_EN
    drive(to_b, (^m) ^ par_flip, OVS);
`endif
    if (stop_low) begin
      // Low across the stop midpoint only, then idle long enough to settle.
      drive(to_b, 1'b0, OVS/2 + 4);
      drive(to_b, 1'b1, OVS/2 - 4 + OVS);
    end else begin
      drive(to_b, 1'b1, OVS*stop_bits);
    end
  endtask

  // Scoreboard for instance A.
  always @(negedge clk) begin
    if (if_a.rx_done_tick) begin
      if (q_a.size() == 0) begin
        chk("a_unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q_a.pop_front();
        chk("a_data", {24'd0, if_a.data}, {23'd0, e.data});
        chk("a_frame_err", {31'd0, if_a.frame_err}, {31'd0, e.fe});
        chk("a_parity_err", {31'd0, if_a.parity_err}, {31'd0, e.pe});
      end
    end
  end

  // Scoreboard for instance B, including done-pulse timing.
  always @(negedge clk) begin
    if (if_b.rx_done_tick) begin
      if (q_b.size() == 0) begin
        chk("b_unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q_b.pop_front();
        chk("b_data", {25'd0, if_b.data}, {23'd0, e.data});
        chk("b_frame_err", {31'd0, if_b.frame_err}, {31'd0, e.fe});
        chk("b_latency", tick_total - b_start_tick, EXP_B_TICKS);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (4) @(posedge clk);
    #1;
    chk("rst_done", {31'd0, if_a.rx_done_tick}, 32'd0);
    chk("rst_data", {24'd0, if_a.data}, 32'd0);
    chk("rst_frame_err", {31'd0, if_a.frame_err}, 32'd0);
    chk("rst_parity_err", {31'd0, if_a.parity_err}, 32'd0);
    rst = 1'b0;
    wait_ticks(4);

    // Clean frames, back-to-back.
    send(1'b0, 9'hA5, 8, 1'b0, 1'b0, 1);
    send(1'b0, 9'h3C, 8, 1'b0, 1'b0, 1);

    // Framing error, then a clean frame clears the flag.
    send(1'b0, 9'h5A, 8, 1'b0, 1'b1, 1);
    send(1'b0, 9'h01, 8, 1'b0, 1'b0, 1);

    // Short low glitch must be rejected.
    drive(1'b0, 1'b0, 4);
    drive(1'b0, 1'b1, 24);
    send(1'b0, 9'hFF, 8, 1'b0, 1'b0, 1);

    // Leave non-zero outputs and a set frame error, then reset mid-frame.
    send(1'b0, 9'h5A, 8, 1'b0, 1'b1, 1);
    drive(1'b0, 1'b0, OVS);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'(8'hC3 >> i), OVS);
    drive(1'b0, 1'b0, OVS/2);
    rx_a = 1'b1;
    rst  = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_rst_done", {31'd0, if_a.rx_done_tick}, 32'd0);
    chk("mid_rst_data", {24'd0, if_a.data}, 32'd0);
    chk("mid_rst_frame_err", {31'd0, if_a.frame_err}, 32'd0);
    chk("mid_rst_parity_err", {31'd0, if_a.parity_err}, 32'd0);
    wait_ticks(40);
    send(1'b0, 9'h81, 8, 1'b0, 1'b0, 1);

`ifdef RX_PARITY_EN
    send(1'b0, 9'h07, 8, 1'b0, 1'b0, 1);
    send(1'b0, 9'h07, 8, 1'b1, 1'b0, 1);
`endif

    // Seven data bits, two stop bits.
    wait_ticks(8);
    send(1'b1, 9'h55, 7, 1'b0, 1'b0, 2);

    wait_ticks(64);
    chk("a_pending", q_a.size(), 32'd0);
    chk("b_pending", q_b.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
